// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI master between NREQ requesters, with slave-select and MISO routing.
module spi_bus_arbiter #(
  parameter int BITS          = 21,
  parameter int NREQ          = 4,
  parameter int NSLAVE        = 4,
  parameter int SW            = $clog2(NSLAVE) + 1,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] req_data,
  input  logic [NREQ*SW-1:0]   req_slave,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [BITS-1:0]      rsp_data,
  output logic [BITS-1:0]      m_data,
  output logic                 m_send,
  input  logic                 m_busy,
  input  logic [BITS-1:0]      m_rdata,
  input  logic                 m_ss,
  output logic [NSLAVE-1:0]    cs_n,
  input  logic [NSLAVE-1:0]    s_miso,
  output logic                 m_miso
);
  localparam int RW = $clog2(NREQ);
  localparam int IW = $clog2(NSLAVE);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, RESP, ERR} state_t;
  state_t          state_q;
  logic [RW-1:0]   rr_q, idx_q, win_d, rr_d;
  logic            found_d;
  logic [SW-1:0]   sel_q, win_sel_d;
  logic            active_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q, done_q, err_q;
  logic            m_send_q;
  logic [BITS-1:0] m_data_q, rsp_q;
  // Descending scan so the candidate closest to rr after the pointer wins.
  always_comb begin
    found_d = 1'b0;
    win_d = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[RW'((int'(rr_q) + j) % NREQ)]) begin
        found_d = 1'b1;
        win_d = RW'((int'(rr_q) + j) % NREQ);
      end
    end
    rr_d = (win_d == RW'(NREQ - 1)) ? '0 : win_d + 1'b1;
    win_sel_d = req_slave[win_d*SW +: SW];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      m_send_q <= 1'b0;
      m_data_q <= '0;
      rsp_q    <= '0;
    end else begin
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      m_send_q <= 1'b0;
      case (state_q)
        IDLE: if (found_d) begin
          idx_q <= win_d;
          sel_q <= win_sel_d;
          rr_q  <= rr_d;
          if (win_sel_d >= SW'(NSLAVE)) begin
            state_q <= ERR;
            err_q   <= NREQ'(1) << win_d;
          end else begin
            state_q  <= SEND;
            gnt_q    <= NREQ'(1) << win_d;
            m_send_q <= 1'b1;
            m_data_q <= req_data[win_d*BITS +: BITS];
            active_q <= 1'b1;
          end
        end
        SEND: begin
          state_q <= WAIT_BUSY;
          cnt_q   <= '0;
        end
        WAIT_BUSY: if (m_busy) state_q <= WAIT_DONE;
          else if (cnt_q + 1'b1 == CW'(START_TIMEOUT)) begin
            state_q  <= ERR;
            err_q    <= NREQ'(1) << idx_q;
            m_data_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        WAIT_DONE: if (!m_busy) begin
          state_q  <= RESP;
          rsp_q    <= m_rdata;
          done_q   <= NREQ'(1) << idx_q;
          m_data_q <= '0;
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end
  for (genvar k = 0; k < NSLAVE; k++) begin : g_cs
    assign cs_n[k] = ~(active_q && sel_q == SW'(k) && !m_ss);
  end
  assign m_miso   = active_q ? s_miso[sel_q[IW-1:0]] : 1'b0;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign m_send   = m_send_q;
  assign m_data   = m_data_q;
  assign rsp_data = rsp_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: scoreboard bench for spi_bus_arbiter with a behavioural SPI master.
module tb_spi_bus_arbiter;
  localparam int BITS = 21, NREQ = 4, NSLAVE = 4, SW = 3;
  logic                 clk, rst, m_send, m_busy, m_ss, m_miso;
  logic [NREQ-1:0]      req, gnt, done, err;
  logic [NREQ*BITS-1:0] req_data;
  logic [NREQ*SW-1:0]   req_slave;
  logic [BITS-1:0]      rsp_data, m_data, m_rdata, key, capt;
  logic [NSLAVE-1:0]    cs_n, s_miso;
  typedef struct {int kind; int idx; logic [BITS-1:0] data; int slave; int cyc;} ev_t;
  ev_t q[$];
  ev_t mon_e;
  logic [3:0] oh;
  logic [BITS-1:0] dv [4];
  int n_chk = 0, n_pass = 0, cyc = 0, cur_slave = -1;
  bit mon_en = 0, busy_en = 1;

  spi_bus_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_slave(req_slave),
    .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data), .m_data(m_data),
    .m_send(m_send), .m_busy(m_busy), .m_rdata(m_rdata), .m_ss(m_ss),
    .cs_n(cs_n), .s_miso(s_miso), .m_miso(m_miso)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void push(input int kind, input int idx, input logic [BITS-1:0] d, input int sl, input int c);
    q.push_back('{kind, idx, d, sl, c});
  endfunction

  function automatic void xfer(input int i, input int sl, input logic [BITS-1:0] d, input logic [BITS-1:0] r, input int gc);
    push(0, i, d, sl, gc);
    push(1, i, r, sl, -1);
  endfunction

  task automatic wait_pulse(input int kind, input int i);
    bit got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = (kind == 0) ? gnt[i] : err[i];
    end
    chk($sformatf("wait_%0d_%0d", kind, i), 64'(got), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_slot(input int i, input int sl, input logic [BITS-1:0] d);
    req_slave[i*SW +: SW] = SW'(sl);
    req_data[i*BITS +: BITS] = d;
  endtask

  // Behavioural master: busy two cycles after m_send, then six cycles of frame, returns m_data ^ key.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (m_send === 1'b1 && busy_en) begin
        capt = m_data ^ key;
        repeat (2) @(posedge clk);
        #1;
        m_busy = 1;
        m_ss = 0;
        repeat (6) @(posedge clk);
        #1;
        m_rdata = capt;
        m_busy = 0;
        m_ss = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!m_ss)
          chk("cs_route", {cs_n, m_miso}, cur_slave < 0 ? 5'b11110 : {~(4'b1 << cur_slave), s_miso[cur_slave]});
        if (m_send || gnt != 0) chk("send_gnt", 64'(m_send), 64'(|gnt));
        if ((gnt | done | err) != 0) begin
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got gnt=%b done=%b err=%b expected none", gnt, done, err);
          end else begin
            mon_e = q.pop_front();
            oh = 4'b1 << mon_e.idx;
            chk("event", {gnt, done, err}, {mon_e.kind == 0 ? oh : 4'h0, mon_e.kind == 1 ? oh : 4'h0, mon_e.kind == 2 ? oh : 4'h0});
            if (mon_e.kind == 0) begin
              chk("gnt_data", {m_send, m_data}, {1'b1, mon_e.data});
              cur_slave = mon_e.slave;
            end
            if (mon_e.kind == 1) chk("done_data", rsp_data, mon_e.data);
            if (mon_e.cyc >= 0) chk("event_cycle", 64'(cyc), 64'(mon_e.cyc));
          end
        end
      end
    end
  end

  initial begin
    rst = 1; req = 0; req_data = 0; req_slave = 0; m_busy = 0; m_ss = 1; m_rdata = 0;
    s_miso = 4'b1010; key = 0;
    repeat (3) @(negedge clk);
    mon_en = 1;
    chk("rst_pulses", {gnt, done, err}, 0);
    chk("rst_master", {m_send, m_data}, 0);
    chk("rst_rsp", rsp_data, 0);
    chk("rst_cs", {cs_n, m_miso}, 5'b11110);
    rst = 0;
    @(negedge clk);
    set_slot(0, 0, 21'h0ABCDE);
    key = 21'h0ABCDE ^ 21'h155555;
    xfer(0, 0, 21'h0ABCDE, 21'h155555, cyc + 1);
    req[0] = 1;
    wait_pulse(0, 0);
    req[0] = 0;
    drain();
    chk("single_rsp_hold", rsp_data, 21'h155555);
    rst = 1;
    @(posedge clk);
    cur_slave = -1;
    @(negedge clk);
    rst = 0;
    key = 21'h0F0F0F;
    for (int i = 0; i < 4; i++) begin
      dv[i] = 21'h100000 + BITS'(i) * 21'h011111;
      set_slot(i, 3 - i, dv[i]);
    end
    for (int n = 0; n < 5; n++) xfer(n % 4, 3 - (n % 4), dv[n % 4], dv[n % 4] ^ key, -1);
    req = 4'hF;
    for (int n = 0; n < 5; n++) wait_pulse(0, n % 4);
    req = 0;
    drain();
    set_slot(3, 1, dv[3]);
    xfer(3, 1, dv[3], dv[3] ^ key, -1);
    req[3] = 1;
    wait_pulse(0, 3);
    req[3] = 0;
    drain();
    xfer(0, 3, dv[0], dv[0] ^ key, -1);
    xfer(2, 1, dv[2], dv[2] ^ key, -1);
    req[0] = 1;
    req[2] = 1;
    wait_pulse(0, 0);
    req[0] = 0;
    wait_pulse(0, 2);
    req[2] = 0;
    drain();
    req_slave[1*SW +: SW] = 3'd5;
    push(2, 1, '0, -1, cyc + 1);
    req[1] = 1;
    wait_pulse(2, 1);
    req[1] = 0;
    chk("inv_cs", {cs_n, m_miso}, 5'b11110);
    drain();
    req_slave[1*SW +: SW] = 3'd2;
    busy_en = 0;
    push(0, 0, dv[0], 3, cyc + 1);
    push(2, 0, '0, -1, cyc + 18);
    req[0] = 1;
    wait_pulse(0, 0);
    req[0] = 0;
    drain();
    busy_en = 1;
    xfer(2, 1, dv[2], dv[2] ^ key, cyc + 1);
    req[2] = 1;
    wait_pulse(0, 2);
    req[2] = 0;
    drain();
    xfer(1, 2, dv[1], dv[1] ^ key, -1);
    req[1] = 1;
    wait_pulse(0, 1);
    req[1] = 0;
    for (int k = 0; k < 50 && !m_busy; k++) @(negedge clk);
    chk("busy_rise", 64'(m_busy), 1);
    @(negedge clk);
    void'(q.pop_back());
    rst = 1;
    @(posedge clk);
    cur_slave = -1;
    @(negedge clk);
    chk("abort_cs", {cs_n, m_miso}, 5'b11110);
    chk("abort_rsp", rsp_data, 0);
    rst = 0;
    repeat (15) @(negedge clk);
    chk("abort_queue", 64'(q.size()), 0);
    key = 21'h1A2B3C;
    xfer(1, 2, dv[1], dv[1] ^ 21'h1A2B3C, cyc + 1);
    req[1] = 1;
    wait_pulse(0, 1);
    req[1] = 0;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
